regbank_alu_datapath: RTL and testbench
=======================================

Name: regbank_alu_datapath

Overview:
- Datapath stage directly downstream of the sequencing state machine.
- Consumes its selects: read decoders A/B, write decoder C, ALU operation.
- Returns the registered Overflow/Carry/Negative/Zero flags the state machine samples.
- Contains an 8-entry register bank, two registered operand latches, an ALU, and a flag register.

Parameters:
- DATAWIDTH, 8, width of every register, operand and ALU result
- SELECTIONALU, 3, width of the ALU operation select
- SELECTIONDECO, 3, width of each register-decoder select
- INIT_RP0, 8'd0, reset value of program register R6
- INIT_RP1, 8'd0, reset value of program register R7

Ports:
- clk  in  1  system clock; all state updates on rising edge
- lowRst  in  1  synchronous reset, active-low
- sSelDecoA  in  SELECTIONDECO  register feeding operand latch A
- sSelDecoB  in  SELECTIONDECO  register feeding operand latch B
- sSelDecoC  in  SELECTIONDECO  destination register; 3'b111 = no write
- sSelAlu  in  SELECTIONALU  ALU operation
- sOverflow  out  1  registered signed-overflow flag
- sCarry  out  1  registered carry/no-borrow flag
- sNegative  out  1  registered result MSB
- sZero  out  1  registered result-equals-zero flag
- rResult  out  DATAWIDTH  current contents of R0
- sAluOut  out  DATAWIDTH  combinational ALU output, for observation only

Behaviour:
- One clock domain. Reset is synchronous and active-low: lowRst sampled only on the rising edge of clk.
- Reset values (lowRst==0 at an edge):
  - R0..R5 = 0; R6 = INIT_RP0; R7 = INIT_RP1
  - operand latches rA = rB = 0
  - all four flags = 0; rResult = 0
- Reset overrides any write or flag update in the same cycle.
- Read latency is one cycle:
  - every edge, rA <= R[sSelDecoA] and rB <= R[sSelDecoB]; the latches are always enabled.
- ALU is combinational from rA/rB:
  - 000 pass A
  - 001 pass B
  - 010 A+B
  - 011 A-B
  - 100 A&B
  - 101 A|B
  - 110 A^B
  - 111 ~A
- Add/sub arithmetic uses DATAWIDTH+1 bits:
  - Carry = bit DATAWIDTH of {0,A}+{0,B} for add, and of {0,A}+{0,~B}+1 for sub (1 = no borrow, i.e. A>=B unsigned).
  - Overflow = two's-complement signed overflow.
  - The result wraps modulo 2^DATAWIDTH.
- Pass and logic ops produce Carry=0 and Overflow=0.
- Negative = result MSB; Zero = (result==0).
- Write and flag update:
  - When sSelDecoC != 3'b111, R[sSelDecoC] <= ALU result and all four flags are updated at the same edge.
  - When sSelDecoC == 3'b111, nothing is written and the flags hold their previous values.
  - R7 is therefore only ever loaded by reset; R6 is writable.
- Sequencer-facing timing:
  - read state for A, then read state for B, then a compute state with sSelDecoC = destination.
  - The result and flags are visible one cycle after the compute state.
- Same-cycle write and read of one register: the latch captures the old value (no forwarding) unless the optional feature is enabled.
- Reset mid-operation: a pending write is discarded and the bank returns to its reset contents on that edge.
- No internal FSM; all sequencing comes from the selects.

Optional Feature:
- Macro REGBANK_BYPASS_EN.
- Defined: if a write is enabled and sSelDecoA (or sSelDecoB) equals sSelDecoC in the same cycle, that latch captures the new ALU result instead of the old register contents.
- Undefined: the latches always capture pre-write register contents.

Decomposition:
- Shared package holds:
  - ALU opcode constants ALU_PASSA..ALU_NOTA
  - the NOWRITE decoder code 3'b111
  - register index constants R0, RP0=3'b110, RP1=3'b111
  - flag bit positions
- Natural sub-module: alu_core, purely combinational (A, B, op -> result, V, C, N, Z).
- Register bank, latches and flags stay in the top module.

Test Plan:
- INIT_RP0=5, INIT_RP1=3; drive A=110 / B=111 / C=000 with op=010 (read, read, compute) -> one cycle later rResult=8, V=0, C=0, N=0, Z=0.
- R6=0x7F, R7=0x01, add into R0 -> rResult=0x80, sOverflow=1, sNegative=1, sCarry=0, sZero=0.
- R6=0xFF, R7=0x01, add -> rResult=0x00, sCarry=1, sZero=1, sOverflow=0.
- Hold flags from the previous test, then compute with sSelDecoC=111 and op=011 -> R0..R7 unchanged and flags still C=1, Z=1.
- Start a compute writing R0=8; assert lowRst=0 on that edge -> R0=0, all flags 0, R6/R7 back to INIT values, deasserting reset resumes cleanly.
- Write R6 (C=110, op=000, rA=0x2A) while sSelDecoA=110 -> next rA is the old R6 without REGBANK_BYPASS_EN, and 0x2A with it.

Source files
------------

// File: rtl/regbank_alu_datapath_pkg.sv
// -----------------------------------------------------------------------------
// regbank_alu_datapath_pkg
// Shared constants for the register-bank / ALU datapath:
//   - ALU opcode encodings (ALU_PASSA .. ALU_NOTA)
//   - decoder codes: register indices and the NOWRITE destination code
//   - bit positions of the packed flag vector {V, C, N, Z}
// Optional feature macro used by the top: REGBANK_BYPASS_EN
// -----------------------------------------------------------------------------
package regbank_alu_datapath_pkg;

    localparam logic [2:0] ALU_PASSA = 3'b000;
    localparam logic [2:0] ALU_PASSB = 3'b001;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b011;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_XOR   = 3'b110;
    localparam logic [2:0] ALU_NOTA  = 3'b111;

    localparam logic [2:0] R0      = 3'b000;
    localparam logic [2:0] RP0     = 3'b110;
    localparam logic [2:0] RP1     = 3'b111;
    // RP1 shares its code with NOWRITE, so R7 can only be loaded by reset.
    localparam logic [2:0] NOWRITE = 3'b111;

    localparam int FLAG_V = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

endpackage

// File: rtl/regbank_alu_datapath_alu_core.sv
// -----------------------------------------------------------------------------
// regbank_alu_datapath_alu_core
// Purely combinational ALU.
// Ports:
//   a_i, b_i   operands (DATAWIDTH)
//   op_i       operation select (SELECTIONALU)
//   result_o   result, wraps modulo 2^DATAWIDTH
//   v_o, c_o   signed overflow / carry (no-borrow on subtract); 0 for pass/logic
//   n_o, z_o   result MSB / result equals zero
// -----------------------------------------------------------------------------
module regbank_alu_datapath_alu_core
    import regbank_alu_datapath_pkg::*;
#(
    parameter int DATAWIDTH    = 8,
    parameter int SELECTIONALU = 3
) (
    input  logic [DATAWIDTH-1:0]    a_i,
    input  logic [DATAWIDTH-1:0]    b_i,
    input  logic [SELECTIONALU-1:0] op_i,
    output logic [DATAWIDTH-1:0]    result_o,
    output logic                    v_o,
    output logic                    c_o,
    output logic                    n_o,
    output logic                    z_o
);

    localparam logic [DATAWIDTH:0] ONE = {{DATAWIDTH{1'b0}}, 1'b1};

    logic [DATAWIDTH:0] sum;

    always_comb begin
        sum      = '0;
        result_o = '0;
        v_o      = 1'b0;
        c_o      = 1'b0;
        case (op_i)
            ALU_PASSA: result_o = a_i;
            ALU_PASSB: result_o = b_i;
            ALU_ADD: begin
                sum      = {1'b0, a_i} + {1'b0, b_i};
                result_o = sum[DATAWIDTH-1:0];
                c_o      = sum[DATAWIDTH];
                // Same-sign operands producing an opposite-sign result.
                v_o      = (a_i[DATAWIDTH-1] == b_i[DATAWIDTH-1]) &&
                           (result_o[DATAWIDTH-1] != a_i[DATAWIDTH-1]);
            end
            ALU_SUB: begin
                // Two's-complement subtract; the carry out is the no-borrow bit.
                sum      = {1'b0, a_i} + {1'b0, ~b_i} + ONE;
                result_o = sum[DATAWIDTH-1:0];
                c_o      = sum[DATAWIDTH];
                v_o      = (a_i[DATAWIDTH-1] != b_i[DATAWIDTH-1]) &&
                           (result_o[DATAWIDTH-1] != a_i[DATAWIDTH-1]);
            end
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_NOTA: result_o = ~a_i;
            default:  result_o = '0;
        endcase
    end

    assign n_o = result_o[DATAWIDTH-1];
    assign z_o = (result_o == '0);

endmodule

// File: rtl/regbank_alu_datapath.sv
// -----------------------------------------------------------------------------
// regbank_alu_datapath
// 8-entry register bank, two always-enabled operand latches, ALU and flag
// register. All sequencing comes from the select inputs.
// Ports:
//   clk            system clock, rising edge
//   lowRst         synchronous reset, active-low
//   sSelDecoA/B    register captured into operand latch A/B every edge
//   sSelDecoC      destination register; NOWRITE (3'b111) = no write, flags hold
//   sSelAlu        ALU operation
//   sOverflow, sCarry, sNegative, sZero   registered flags
//   rResult        contents of R0
//   sAluOut        combinational ALU output (observation only)
// Optional feature: define REGBANK_BYPASS_EN to forward the ALU result into an
// operand latch whose read select matches the register being written.
// -----------------------------------------------------------------------------
module regbank_alu_datapath
    import regbank_alu_datapath_pkg::*;
#(
    parameter int                 DATAWIDTH     = 8,
    parameter int                 SELECTIONALU  = 3,
    parameter int                 SELECTIONDECO = 3,
    parameter logic [DATAWIDTH-1:0] INIT_RP0    = 8'd0,
    parameter logic [DATAWIDTH-1:0] INIT_RP1    = 8'd0
) (
    input  logic                     clk,
    input  logic                     lowRst,
    input  logic [SELECTIONDECO-1:0] sSelDecoA,
    input  logic [SELECTIONDECO-1:0] sSelDecoB,
    input  logic [SELECTIONDECO-1:0] sSelDecoC,
    input  logic [SELECTIONALU-1:0]  sSelAlu,
    output logic                     sOverflow,
    output logic                     sCarry,
    output logic                     sNegative,
    output logic                     sZero,
    output logic [DATAWIDTH-1:0]     rResult,
    output logic [DATAWIDTH-1:0]     sAluOut
);

    logic [DATAWIDTH-1:0] bank_q [8];
    logic [DATAWIDTH-1:0] ra_q, ra_d;
    logic [DATAWIDTH-1:0] rb_q, rb_d;
    logic [3:0]           flags_q, flags_d;

    logic                 wr_en;
    logic [DATAWIDTH-1:0] alu_res;
    logic                 alu_v, alu_c, alu_n, alu_z;

    regbank_alu_datapath_alu_core #(
        .DATAWIDTH    (DATAWIDTH),
        .SELECTIONALU (SELECTIONALU)
    ) u_alu_core (
        .a_i      (ra_q),
        .b_i      (rb_q),
        .op_i     (sSelAlu),
        .result_o (alu_res),
        .v_o      (alu_v),
        .c_o      (alu_c),
        .n_o      (alu_n),
        .z_o      (alu_z)
    );

    assign wr_en = (sSelDecoC != NOWRITE);

    always_comb begin
        ra_d    = bank_q[sSelDecoA];
        rb_d    = bank_q[sSelDecoB];
        flags_d = flags_q;
`ifdef REGBANK_BYPASS_EN
        if (wr_en && (sSelDecoA == sSelDecoC)) ra_d = alu_res;
        if (wr_en && (sSelDecoB == sSelDecoC)) rb_d = alu_res;
`endif
        if (wr_en) begin
            flags_d[FLAG_V] = alu_v;
            flags_d[FLAG_C] = alu_c;
            flags_d[FLAG_N] = alu_n;
            flags_d[FLAG_Z] = alu_z;
        end
    end

    always_ff @(posedge clk) begin
        if (!lowRst) begin
            for (int i = 0; i < 6; i++) bank_q[i] <= '0;
            bank_q[RP0] <= INIT_RP0;
            bank_q[RP1] <= INIT_RP1;
            ra_q        <= '0;
            rb_q        <= '0;
            flags_q     <= '0;
        end else begin
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            flags_q <= flags_d;
            if (wr_en) bank_q[sSelDecoC] <= alu_res;
        end
    end

    assign rResult   = bank_q[R0];
    assign sAluOut   = alu_res;
    assign sOverflow = flags_q[FLAG_V];
    assign sCarry    = flags_q[FLAG_C];
    assign sNegative = flags_q[FLAG_N];
    assign sZero     = flags_q[FLAG_Z];

endmodule

// File: tb/tb_regbank_alu_datapath.sv
module tb_regbank_alu_datapath;

    logic       clk = 1'b0;
    logic       lowRst;
    logic [2:0] sSelDecoA, sSelDecoB, sSelDecoC, sSelAlu;
    logic       sOverflow, sCarry, sNegative, sZero;
    logic [7:0] rResult, sAluOut;

    int assertions = 0;
    int failures   = 0;

    // Reference state: register contents and flags {V,C,N,Z}.
    logic [7:0] m [8];
    logic [3:0] mflags;

    regbank_alu_datapath #(
        .DATAWIDTH     (8),
        .SELECTIONALU  (3),
        .SELECTIONDECO (3),
        .INIT_RP0      (8'd5),
        .INIT_RP1      (8'd3)
    ) dut (
        .clk       (clk),
        .lowRst    (lowRst),
        .sSelDecoA (sSelDecoA),
        .sSelDecoB (sSelDecoB),
        .sSelDecoC (sSelDecoC),
        .sSelAlu   (sSelAlu),
        .sOverflow (sOverflow),
        .sCarry    (sCarry),
        .sNegative (sNegative),
        .sZero     (sZero),
        .rResult   (rResult),
        .sAluOut   (sAluOut)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m[i] = 8'd0;
        m[6]   = 8'd5;
        m[7]   = 8'd3;
        mflags = 4'b0000;
    endtask

    // Arithmetic done on plain integers, straight from the operation definitions.
    task automatic model_alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                             output logic [7:0] r, output logic [3:0] f);
        int ua, ub, sa, sb, s, sv;
        logic v, c;
        ua = int'(a); ub = int'(b);
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        v = 1'b0; c = 1'b0;
        case (op)
            3'd0: r = a;
            3'd1: r = b;
            3'd2: begin
                s = ua + ub; r = s[7:0]; c = (s > 255);
                sv = sa + sb; v = (sv > 127) || (sv < -128);
            end
            3'd3: begin
                s = ua - ub; r = s[7:0]; c = (ua >= ub);
                sv = sa - sb; v = (sv > 127) || (sv < -128);
            end
            3'd4: r = a & b;
            3'd5: r = a | b;
            3'd6: r = a ^ b;
            default: r = ~a;
        endcase
        f = {v, c, r[7], (r == 8'd0)};
    endtask

    // Read cycle for A/B, then compute cycle with destination c.
    task automatic do_op(input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] c, input logic [2:0] op);
        logic [7:0] r;
        logic [3:0] f;
        sSelDecoA = a; sSelDecoB = b; sSelDecoC = 3'd7; sSelAlu = op;
        step();
        sSelDecoC = c;
        step();
        sSelDecoC = 3'd7;
        model_alu(m[a], m[b], op, r, f);
        if (c != 3'd7) begin
            m[c]   = r;
            mflags = f;
        end
    endtask

    // Builds a constant in dest by doubling and adding R5 (which holds 1).
    task automatic load_const(input logic [2:0] dest, input logic [7:0] val);
        logic [7:0] v;
        v = val;
        do_op(3'd5, 3'd5, dest, 3'd6);
        for (int i = 7; i >= 0; i--) begin
            do_op(dest, dest, dest, 3'd2);
            if (v[i]) do_op(dest, 3'd5, dest, 3'd2);
        end
    endtask

    task automatic test_reset();
        lowRst = 1'b0;
        sSelDecoA = 3'd6; sSelDecoB = 3'd7; sSelDecoC = 3'd0; sSelAlu = 3'd0;
        step();
        step();
        model_reset();
        assertions++;
        if (rResult !== 8'd0) begin
            failures++; $display("FAIL reset_rResult actual=%h required=00", rResult);
        end
        assertions++;
        if ({sOverflow, sCarry, sNegative, sZero} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags actual=%b required=0000",
                                 {sOverflow, sCarry, sNegative, sZero});
        end
        assertions++;
        if (sAluOut !== 8'd0) begin
            failures++; $display("FAIL reset_latchA actual=%h required=00", sAluOut);
        end
        lowRst = 1'b1;
        sSelDecoC = 3'd7;
        for (int i = 6; i < 8; i++) begin
            do_op(3'(i), 3'(i), 3'd7, 3'd0);
            assertions++;
            if (sAluOut !== m[i]) begin
                failures++; $display("FAIL reset_R%0d actual=%h required=%h", i, sAluOut, m[i]);
            end
        end
    endtask

    task automatic test_basic_add();
        do_op(3'd6, 3'd7, 3'd0, 3'd2);
        assertions++;
        if (rResult !== 8'd8 || rResult !== m[0]) begin
            failures++; $display("FAIL basic_add_result actual=%h required=08", rResult);
        end
        assertions++;
        if ({sOverflow, sCarry, sNegative, sZero} !== 4'b0000) begin
            failures++; $display("FAIL basic_add_flags actual=%b required=0000",
                                 {sOverflow, sCarry, sNegative, sZero});
        end
    endtask

    task automatic test_reset_mid_op();
        do_op(3'd0, 3'd0, 3'd0, 3'd6);
        sSelDecoA = 3'd6; sSelDecoB = 3'd7; sSelDecoC = 3'd7; sSelAlu = 3'd2;
        step();
        sSelDecoC = 3'd0;
        lowRst = 1'b0;
        step();
        lowRst = 1'b1;
        sSelDecoC = 3'd7;
        model_reset();
        assertions++;
        if (rResult !== 8'd0) begin
            failures++; $display("FAIL midrst_rResult actual=%h required=00", rResult);
        end
        assertions++;
        if ({sOverflow, sCarry, sNegative, sZero} !== 4'b0000) begin
            failures++; $display("FAIL midrst_flags actual=%b required=0000",
                                 {sOverflow, sCarry, sNegative, sZero});
        end
        do_op(3'd6, 3'd7, 3'd0, 3'd2);
        assertions++;
        if (rResult !== 8'd8) begin
            failures++; $display("FAIL midrst_resume actual=%h required=08", rResult);
        end
    endtask

    task automatic test_flag_edges();
        do_op(3'd6, 3'd7, 3'd2, 3'd3);   // R2 = 2
        do_op(3'd7, 3'd2, 3'd5, 3'd3);   // R5 = 1
        load_const(3'd6, 8'h7F);
        load_const(3'd4, 8'h01);
        do_op(3'd6, 3'd4, 3'd0, 3'd2);
        assertions++;
        if (rResult !== 8'h80) begin
            failures++; $display("FAIL ovf_result actual=%h required=80", rResult);
        end
        assertions++;
        if ({sOverflow, sCarry, sNegative, sZero} !== 4'b1010) begin
            failures++; $display("FAIL ovf_flags actual=%b required=1010",
                                 {sOverflow, sCarry, sNegative, sZero});
        end
        load_const(3'd6, 8'hFF);
        do_op(3'd6, 3'd4, 3'd0, 3'd2);
        assertions++;
        if (rResult !== 8'h00) begin
            failures++; $display("FAIL carry_result actual=%h required=00", rResult);
        end
        assertions++;
        if ({sOverflow, sCarry, sNegative, sZero} !== 4'b0101) begin
            failures++; $display("FAIL carry_flags actual=%b required=0101",
                                 {sOverflow, sCarry, sNegative, sZero});
        end
    endtask

    task automatic test_nowrite_hold();
        do_op(3'd6, 3'd7, 3'd7, 3'd3);
        assertions++;
        if ({sOverflow, sCarry, sNegative, sZero} !== 4'b0101) begin
            failures++; $display("FAIL hold_flags actual=%b required=0101",
                                 {sOverflow, sCarry, sNegative, sZero});
        end
        for (int i = 0; i < 8; i++) begin
            do_op(3'(i), 3'(i), 3'd7, 3'd1);
            assertions++;
            if (sAluOut !== m[i]) begin
                failures++; $display("FAIL hold_R%0d actual=%h required=%h", i, sAluOut, m[i]);
            end
        end
    endtask

    task automatic test_bypass();
        logic [7:0] old_r6, exp;
        load_const(3'd4, 8'h2A);
        old_r6 = m[6];
        sSelDecoA = 3'd4; sSelDecoB = 3'd4; sSelDecoC = 3'd7; sSelAlu = 3'd0;
        step();
        sSelDecoA = 3'd6; sSelDecoC = 3'd6;
        step();
        sSelDecoC = 3'd7;
        m[6] = 8'h2A;
        mflags = 4'b0000;
`ifdef REGBANK_BYPASS_EN
        exp = 8'h2A;
`else
        exp = old_r6;
`endif
        assertions++;
        if (sAluOut !== exp) begin
            failures++; $display("FAIL bypass_latch actual=%h required=%h", sAluOut, exp);
        end
        step();
        assertions++;
        if (sAluOut !== m[6]) begin
            failures++; $display("FAIL bypass_r6 actual=%h required=%h", sAluOut, m[6]);
        end
    endtask

    task automatic test_random();
        logic [2:0] a, b, c, op;
        for (int n = 0; n < 60; n++) begin
            a  = 3'($urandom_range(0, 7));
            b  = 3'($urandom_range(0, 7));
            c  = 3'($urandom_range(0, 7));
            op = 3'($urandom_range(0, 7));
            do_op(a, b, c, op);
            assertions++;
            if (rResult !== m[0]) begin
                failures++; $display("FAIL rand%0d_rResult actual=%h required=%h", n, rResult, m[0]);
            end
            assertions++;
            if ({sOverflow, sCarry, sNegative, sZero} !== mflags) begin
                failures++; $display("FAIL rand%0d_flags actual=%b required=%b", n,
                                     {sOverflow, sCarry, sNegative, sZero}, mflags);
            end
        end
        for (int i = 0; i < 8; i++) begin
            do_op(3'(i), 3'(i), 3'd7, 3'd0);
            assertions++;
            if (sAluOut !== m[i]) begin
                failures++; $display("FAIL rand_final_R%0d actual=%h required=%h", i, sAluOut, m[i]);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_add();
        test_reset_mid_op();
        test_flag_edges();
        test_nowrite_hold();
        test_bypass();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
